// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the two-requester cache arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;

    // One transaction in flight: grant, one issue cycle, then wait for the cache.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arb_rr.sv
// Two-input round-robin picker: returns the one-hot winner among active requests.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module cache_arb_rr (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] winner
);

    // A lone request always wins; on a tie the pointer names the favoured side.
    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = rr_ptr ? 2'b10 : 2'b01;
            default: winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/cache_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port cache; optional stats (CACHE_ARB_STATS_EN).
// Latency: grant on the first edge seeing req, one issue cycle, done one edge after c_response is seen in WAIT.
// Backpressure: a requester waits while the other owns the cache; the cache stalls via c_response low.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic [1:0]          wr,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          done,
    output logic [DATA_W-1:0]   rdata,
    output logic                miss,
    output logic [ADDR_W-1:0]   c_addr,
    output logic [DATA_W-1:0]   c_data,
    output logic                c_wr,
    input  logic                c_response,
    input  logic                c_is_missrate,
    input  logic [DATA_W-1:0]   c_out,
    output logic [CNT_W-1:0]    req_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);

    arb_state_t          state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                miss_q, miss_d;
    logic [ADDR_W-1:0]   c_addr_q, c_addr_d;
    logic [DATA_W-1:0]   c_data_q, c_data_d;
    logic                c_wr_q, c_wr_d;
    logic                rr_q, rr_d;
    logic [1:0]          winner;
    logic                win_idx;

    cache_arb_rr u_rr (
        .req    (req),
        .rr_ptr (rr_q),
        .winner (winner)
    );

    assign win_idx = winner[1];

    // Next-state and output decode; the op of the owner is latched at grant and held for the cache.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = 2'b00;
        rdata_d  = rdata_q;
        miss_d   = miss_q;
        c_addr_d = c_addr_q;
        c_data_d = c_data_q;
        c_wr_d   = c_wr_q;
        rr_d     = rr_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt_d    = winner;
                    c_addr_d = win_idx ? addr[ADDR_W +: ADDR_W] : addr[0 +: ADDR_W];
                    c_data_d = win_idx ? wdata[DATA_W +: DATA_W] : wdata[0 +: DATA_W];
                    c_wr_d   = win_idx ? wr[1] : wr[0];
                    rr_d     = ~win_idx;
                    state_d  = ISSUE;
                end
            end
            // The cache needs one cycle to see the new drive, so c_response is ignored here.
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (c_response) begin
                    done_d  = gnt_q;
                    gnt_d   = 2'b00;
                    state_d = IDLE;
                    if (c_wr_q) begin
                        miss_d = 1'b0;
                    end else begin
                        rdata_d = c_out;
                        miss_d  = c_is_missrate;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // Arbiter state register; reset drops any in-flight op without a done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            rdata_q  <= '0;
            miss_q   <= 1'b0;
            c_addr_q <= '0;
            c_data_q <= '0;
            c_wr_q   <= 1'b0;
            rr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            miss_q   <= miss_d;
            c_addr_q <= c_addr_d;
            c_data_q <= c_data_d;
            c_wr_q   <= c_wr_d;
            rr_q     <= rr_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign rdata  = rdata_q;
    assign miss   = miss_q;
    assign c_addr = c_addr_q;
    assign c_data = c_data_q;
    assign c_wr   = c_wr_q;

`ifdef CACHE_ARB_STATS_EN
    logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             grant_fire;
    logic             rd_miss_fire;

    // Saturating event counters: one per grant, one per read that completed as a miss.
    always_comb begin
        grant_fire   = (state_q == IDLE) && (req != 2'b00);
        rd_miss_fire = (state_q == WAIT) && c_response && !c_wr_q && c_is_missrate;
        req_cnt_d    = req_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (grant_fire && (req_cnt_q != '1)) begin
            req_cnt_d = req_cnt_q + CNT_W'(1);
        end
        if (rd_miss_fire && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            req_cnt_q  <= req_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign req_cnt  = req_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign req_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule
